// File: rtl/bp_pkg.sv
// Shared types for the branch resolve controller.
//   bp_state_e : controller FSM states (RUN, FLUSH)
//   inflight_t : one queued branch {pc, pred_taken, pred_target}
//   BP_XLEN    : address width of the queued entry fields
//   ST_W       : FSM state encoding width
package bp_pkg;

  localparam int BP_XLEN = 32;
  localparam int ST_W    = 1;

  typedef enum logic [ST_W-1:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic [BP_XLEN-1:0] pc;
    logic               pred_taken;
    logic [BP_XLEN-1:0] pred_target;
  } inflight_t;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Bus bundle between the pipeline (master) and branch_resolve_ctrl (slave).
//   decode side : d_valid, d_is_branch, d_pc, d_pred_taken, d_pred_target
//   exec side   : x_resolve, x_taken, x_target
//   control     : stall_d, flush_fd, redirect_valid, redirect_pc
//   predictor   : bp_upd_valid, bp_upd_pc, bp_upd_taken, bp_upd_target
//   status      : err_underflow (+ stat_branches, stat_mispredicts when
//                 BRANCH_STATS_EN is defined)
interface branch_resolve_ctrl_if #(
  parameter int XLEN = 32
);

  logic            d_valid;
  logic            d_is_branch;
  logic [XLEN-1:0] d_pc;
  logic            d_pred_taken;
  logic [XLEN-1:0] d_pred_target;
  logic            x_resolve;
  logic            x_taken;
  logic [XLEN-1:0] x_target;
  logic            stall_d;
  logic            flush_fd;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            bp_upd_valid;
  logic [XLEN-1:0] bp_upd_pc;
  logic            bp_upd_taken;
  logic [XLEN-1:0] bp_upd_target;
  logic            err_underflow;
`ifdef BRANCH_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  modport master (
    output d_valid, d_is_branch, d_pc, d_pred_taken, d_pred_target,
    output x_resolve, x_taken, x_target,
    input  stall_d, flush_fd, redirect_valid, redirect_pc,
    input  bp_upd_valid, bp_upd_pc, bp_upd_taken, bp_upd_target,
    input  err_underflow
`ifdef BRANCH_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  d_valid, d_is_branch, d_pc, d_pred_taken, d_pred_target,
    input  x_resolve, x_taken, x_target,
    output stall_d, flush_fd, redirect_valid, redirect_pc,
    output bp_upd_valid, bp_upd_pc, bp_upd_taken, bp_upd_target,
    output err_underflow
`ifdef BRANCH_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );

endinterface

// File: rtl/bp_inflight_fifo.sv
// In-flight branch queue: DEPTH entries (power of 2), head read combinationally.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/push_data, pop : enqueue / dequeue (both in one cycle is legal)
//   clear      : drop every entry (wins over push/pop)
//   head       : oldest entry, count : occupancy, empty : count == 0
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  inflight_t        push_data,
  input  logic             pop,
  input  logic             clear,
  output inflight_t        head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  inflight_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: queues decoded branches with their fetch-time
// prediction, checks each against the exec outcome, trains the predictor for
// every resolved branch and, on a mispredict, redirects fetch and flushes the
// fetch/decode stages for FLUSH_CYCLES cycles.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : branch_resolve_ctrl_if.slave (decode/exec inputs, control,
//           predictor update and status outputs)
// Optional: define BRANCH_STATS_EN to add saturating stat_branches and
// stat_mispredicts counters to the bus.
module branch_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int XLEN         = BP_XLEN,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bp_state_e        state, state_nxt;
  logic [FC_W-1:0]  fcnt, fcnt_nxt;

  inflight_t        push_entry;
  inflight_t        head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;

  logic             resolve_ok;
  logic             underflow;
  logic             mispredict_now;
  logic             push;
  logic [XLEN-1:0]  head_pc;
  logic [XLEN-1:0]  head_tgt;

  logic             vld_p1;
  logic [XLEN-1:0]  upd_pc_p1;
  logic             upd_taken_p1;
  logic [XLEN-1:0]  upd_target_p1;
  logic             redir_vld_p1;
  logic [XLEN-1:0]  redir_pc_p1;
  logic             err_p1;

  // ---- stage p0: queue, compare, push/pop decisions ----
  assign head_pc  = XLEN'(head.pc);
  assign head_tgt = XLEN'(head.pred_target);

  // In FLUSH the queue is already empty, so any resolve is an underflow.
  assign resolve_ok = bus.x_resolve & (state == RUN) & ~fifo_empty;
  assign underflow  = bus.x_resolve & ~resolve_ok;

  assign mispredict_now = resolve_ok &
                          ((head.pred_taken != bus.x_taken) |
                           (bus.x_taken & (head_tgt != bus.x_target)));

  // A same-cycle pop frees the slot, so a full queue still accepts a push.
  assign bus.stall_d = (fifo_count == CNT_W'(DEPTH)) & ~bus.x_resolve;

  assign push = bus.d_valid & bus.d_is_branch & ~bus.stall_d &
                (state == RUN) & ~mispredict_now;

  assign push_entry.pc          = BP_XLEN'(bus.d_pc);
  assign push_entry.pred_taken  = bus.d_pred_taken;
  assign push_entry.pred_target = BP_XLEN'(bus.d_pred_target);

  bp_inflight_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (resolve_ok),
    .clear     (mispredict_now),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // fcnt is loaded with FLUSH_CYCLES-1 so FLUSH lasts exactly FLUSH_CYCLES.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    case (state)
      RUN: begin
        if (mispredict_now) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (fcnt == '0) state_nxt = RUN;
        else            fcnt_nxt  = fcnt - FC_W'(1);
      end
      default: state_nxt = RUN;
    endcase
  end

  // ---- stage p1: registered predictor update / redirect / status ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      upd_pc_p1     <= '0;
      upd_taken_p1  <= 1'b0;
      upd_target_p1 <= '0;
      redir_vld_p1  <= 1'b0;
      redir_pc_p1   <= '0;
      err_p1        <= 1'b0;
    end else begin
      vld_p1        <= resolve_ok;
      upd_pc_p1     <= head_pc;
      upd_taken_p1  <= bus.x_taken;
      upd_target_p1 <= bus.x_taken ? bus.x_target : head_tgt;
      redir_vld_p1  <= mispredict_now;
      redir_pc_p1   <= bus.x_taken ? bus.x_target : head_pc + XLEN'(4);
      err_p1        <= err_p1 | underflow;
    end
  end

  assign bus.flush_fd       = (state == FLUSH);
  assign bus.redirect_valid = redir_vld_p1;
  assign bus.redirect_pc    = redir_pc_p1;
  assign bus.bp_upd_valid   = vld_p1;
  assign bus.bp_upd_pc      = upd_pc_p1;
  assign bus.bp_upd_taken   = upd_taken_p1;
  assign bus.bp_upd_target  = upd_target_p1;
  assign bus.err_underflow  = err_p1;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_p1;
  logic [31:0] stat_mis_p1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_p1  <= '0;
      stat_mis_p1 <= '0;
    end else begin
      if (resolve_ok)     stat_br_p1  <= sat_inc(stat_br_p1);
      if (mispredict_now) stat_mis_p1 <= sat_inc(stat_mis_p1);
    end
  end

  assign bus.stat_branches    = stat_br_p1;
  assign bus.stat_mispredicts = stat_mis_p1;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl. A reference model tracks the
// in-flight queue and flush window; each cycle's expected registered outputs
// are pushed to a scoreboard queue and popped one cycle later for comparison.
module tb_branch_resolve_ctrl;

  localparam int XLEN         = 32;
  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;

  logic clk;
  logic rst_n;

  branch_resolve_ctrl_if #(.XLEN(XLEN)) bus ();

  branch_resolve_ctrl #(
    .XLEN         (XLEN),
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        utk;
    logic [31:0] utgt;
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
  } ent_t;

  exp_t sb[$];
  ent_t mq[$];
  int   mflush;
  logic merr;
  int   n_vec;
  int   n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle_inputs();
    bus.d_valid       = 1'b0;
    bus.d_is_branch   = 1'b0;
    bus.d_pc          = '0;
    bus.d_pred_taken  = 1'b0;
    bus.d_pred_target = '0;
    bus.x_resolve     = 1'b0;
    bus.x_taken       = 1'b0;
    bus.x_target      = '0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_flush"},  {31'd0, bus.flush_fd},       32'd0);
    chk({pfx, "_redir"},  {31'd0, bus.redirect_valid}, 32'd0);
    chk({pfx, "_rpc"},    bus.redirect_pc,             32'd0);
    chk({pfx, "_upd"},    {31'd0, bus.bp_upd_valid},   32'd0);
    chk({pfx, "_updpc"},  bus.bp_upd_pc,               32'd0);
    chk({pfx, "_err"},    {31'd0, bus.err_underflow},  32'd0);
    chk({pfx, "_stall"},  {31'd0, bus.stall_d},        32'd0);
  endtask

  // Called at posedge+1; applies one cycle of inputs, checks the outputs
  // registered at the previous edge, then advances to the next posedge+1.
  task automatic cyc(input logic dv, input logic [31:0] dpc, input logic pt,
                     input logic [31:0] ptgt, input logic res, input logic xt,
                     input logic [31:0] xtgt);
    exp_t e;
    exp_t ne;
    ent_t h;
    logic stall_exp;
    logic in_flush;
    logic mis;
    bus.d_valid       = dv;
    bus.d_is_branch   = dv;
    bus.d_pc          = dpc;
    bus.d_pred_taken  = pt;
    bus.d_pred_target = ptgt;
    bus.x_resolve     = res;
    bus.x_taken       = xt;
    bus.x_target      = xtgt;
    #1;
    e = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0};
    if (sb.size() > 0) e = sb.pop_front();
    chk("upd_valid", {31'd0, bus.bp_upd_valid}, {31'd0, e.uv});
    if (e.uv) begin
      chk("upd_pc",     bus.bp_upd_pc,                 e.upc);
      chk("upd_taken",  {31'd0, bus.bp_upd_taken},     {31'd0, e.utk});
      chk("upd_target", bus.bp_upd_target,             e.utgt);
    end
    chk("redir_valid", {31'd0, bus.redirect_valid}, {31'd0, e.rv});
    if (e.rv) chk("redir_pc", bus.redirect_pc, e.rpc);
    in_flush  = (mflush > 0);
    stall_exp = (mq.size() == DEPTH) && !res;
    chk("err_underflow", {31'd0, bus.err_underflow}, {31'd0, merr});
    chk("flush_fd",      {31'd0, bus.flush_fd},      {31'd0, in_flush});
    chk("stall_d",       {31'd0, bus.stall_d},       {31'd0, stall_exp});
    // Reference model for this cycle.
    ne  = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0};
    mis = 1'b0;
    if (res) begin
      if (in_flush || mq.size() == 0) begin
        merr = 1'b1;
      end else begin
        h       = mq.pop_front();
        mis     = (h.pt != xt) || (xt && (h.ptgt != xtgt));
        ne.uv   = 1'b1;
        ne.upc  = h.pc;
        ne.utk  = xt;
        ne.utgt = xt ? xtgt : h.ptgt;
        if (mis) begin
          ne.rv  = 1'b1;
          ne.rpc = xt ? xtgt : h.pc + 32'd4;
          mq.delete();
        end
      end
    end
    if (dv && !stall_exp && !in_flush && !mis) mq.push_back('{dpc, pt, ptgt});
    if (mis)           mflush = FLUSH_CYCLES;
    else if (in_flush) mflush--;
    sb.push_back(ne);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic push_br(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    cyc(1'b1, pc, pt, ptgt, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic resolve(input logic xt, input logic [31:0] xtgt);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, xt, xtgt);
  endtask

  task automatic model_clear();
    sb.delete();
    mq.delete();
    mflush = 0;
    merr   = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_clear();
    drive_idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: correct taken prediction.
    push_br(32'h0000_1014, 1'b1, 32'h0000_1000);
    resolve(1'b1, 32'h0000_1000);
    idle();
    idle();

    // 2: predicted not-taken, actually taken; same-cycle push is dropped,
    // and a push during the flush window is ignored.
    push_br(32'h0000_1008, 1'b0, 32'h0000_0000);
    cyc(1'b1, 32'h0000_3000, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_1010);
    push_br(32'h0000_3004, 1'b0, 32'd0);
    idle();
    idle();

    // 3: predicted taken, actually not-taken -> fall-through redirect.
    push_br(32'h0000_100c, 1'b1, 32'h0000_1014);
    resolve(1'b0, 32'd0);
    idle();
    idle();
    idle();

    // 4: fill the queue, stall, then push with same-cycle pop.
    for (int i = 0; i < DEPTH; i++)
      push_br(32'h0000_2000 + 32'(4 * i), 1'b0, 32'd0);
    push_br(32'h0000_2010, 1'b0, 32'd0);
    cyc(1'b1, 32'h0000_2010, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    push_br(32'h0000_2014, 1'b0, 32'd0);
    for (int i = 0; i < DEPTH; i++) resolve(1'b0, 32'd0);
    idle();

    // Taken with wrong target.
    push_br(32'h0000_5000, 1'b1, 32'h0000_6000);
    resolve(1'b1, 32'h0000_6004);
    idle();
    idle();
    idle();

    // 5: fall-through address wraps.
    push_br(32'hFFFF_FFFC, 1'b1, 32'h0000_0100);
    resolve(1'b0, 32'd0);
    idle();
    idle();
    idle();

    // 6: resolve with an empty queue, then reset in the middle of a flush.
    resolve(1'b1, 32'h0000_0040);
    idle();
    idle();
    push_br(32'h0000_4000, 1'b0, 32'd0);
    resolve(1'b1, 32'h0000_4100);
    idle();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_flush");
    model_clear();
    drive_idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_br(32'h0000_7000, 1'b1, 32'h0000_7100);
    resolve(1'b1, 32'h0000_7100);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
